// File: rtl/lfsr_burst_gen.sv
// LFSR / counter test-traffic source for a FIFO write port, burst or continuous.
// Optional GEN_CHKSUM_EN adds chk, the XOR of accepted words since start.
module lfsr_burst_gen #(
    parameter int unsigned              DATA_W  = 8,
    parameter int unsigned              LFSR_W  = 7,
    parameter logic [LFSR_W-1:0]        TAPS    = 7'b1100101,
    parameter logic [LFSR_W-1:0]        SEED    = 7'h01,
    parameter int unsigned              BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_gen,
    input  logic               en_wrk,
    input  logic               full,
    input  logic               mode,
    input  logic               seed_ld,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [BURST_W-1:0] burst_len,
    output logic               wrreq,
    output logic [DATA_W-1:0]  data,
    output logic               busy,
    output logic               done,
`ifdef GEN_CHKSUM_EN
    output logic [DATA_W-1:0]  chk,
`endif
    output logic [BURST_W-1:0] word_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, next_state;
    logic [LFSR_W-1:0]   lfsr;
    logic [DATA_W-1:0]   ctr;
    logic                mode_q;
    logic [BURST_W-1:0]  len_q;
    logic                en_gen_q;
    logic                start;
    logic                last;

    assign data = mode_q ? ctr : DATA_W'(lfsr);

    always_comb begin
        next_state = state;
        wrreq      = 1'b0;
        busy       = 1'b0;
        start      = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                start = en_gen & ~en_gen_q;
                if (start)
                    next_state = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                wrreq = en_wrk & ~full;
                last  = wrreq && (len_q != '0)
                        && (word_cnt == len_q - BURST_W'(1));
                // a completed burst wins over a simultaneous abort
                if (last || !en_gen)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= SEED;
            ctr      <= '0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
            en_gen_q <= 1'b0;
`ifdef GEN_CHKSUM_EN
            chk      <= '0;
`endif
        end else begin
            en_gen_q <= en_gen;
            done     <= last;
            if (start) begin
                mode_q   <= mode;
                len_q    <= burst_len;
                ctr      <= '0;
                word_cnt <= '0;
`ifdef GEN_CHKSUM_EN
                chk      <= '0;
`endif
            end
            // all-zero seed would lock the LFSR up
            if (state == IDLE && seed_ld)
                lfsr <= (seed == '0) ? SEED : seed;
            if (wrreq) begin
                lfsr     <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
                ctr      <= ctr + DATA_W'(1);
                word_cnt <= word_cnt + BURST_W'(1);
`ifdef GEN_CHKSUM_EN
                chk      <= chk ^ data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Directed self-checking bench for lfsr_burst_gen.
// Expected words are hand-derived from x^7+x^6+x^3+x+1 stepping.
module tb_lfsr_burst_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_gen, en_wrk, full, mode, seed_ld;
    logic [6:0] seed;
    logic [7:0] burst_len;
    logic       wrreq, busy, done;
    logic [7:0] data, word_cnt;
`ifdef GEN_CHKSUM_EN
    logic [7:0] chk;
`endif

    int errs = 0;
    int nchk = 0;
    int nd;

    lfsr_burst_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en_gen    (en_gen),
        .en_wrk    (en_wrk),
        .full      (full),
        .mode      (mode),
        .seed_ld   (seed_ld),
        .seed      (seed),
        .burst_len (burst_len),
        .wrreq     (wrreq),
        .data      (data),
        .busy      (busy),
        .done      (done),
`ifdef GEN_CHKSUM_EN
        .chk       (chk),
`endif
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1 [4] = '{8'h01, 8'h03, 8'h07, 8'h0E};
    logic [7:0] t3 [3] = '{8'h07, 8'h0E, 8'h1D};

    initial begin
        rst = 1'b1; en_gen = 0; en_wrk = 0; full = 0; mode = 0;
        seed_ld = 0; seed = '0; burst_len = '0;
        #2;
        check("rst_wrreq", wrreq, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_data", data, 8'h01);
        tick();
        rst = 1'b0;
        tick();

        // burst of 4 LFSR words from seed 01
        seed_ld = 1; seed = 7'h01; en_gen = 1; mode = 0;
        burst_len = 8'd4; en_wrk = 1;
        tick();
        seed_ld = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_wrreq", wrreq, 1);
            check("t1_data", data, t1[i]);
            tick();
        end
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_cnt", word_cnt, 8'd4);
        check("t1_wrreq_idle", wrreq, 0);
`ifdef GEN_CHKSUM_EN
        check("t1_chk", chk, 8'h0B);
`endif
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_no_retrig", busy, 0);

        // counter mode, 3 words
        en_gen = 0;
        tick();
        en_gen = 1; mode = 1; burst_len = 8'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_data", data, i);
            tick();
        end
        check("t2_done", done, 1);
        check("t2_cnt", word_cnt, 8'd3);
        en_gen = 0;
        tick();

        // continuous counter mode, wrap of data and word_cnt
        en_gen = 1; mode = 1; burst_len = 8'd0;
        tick();
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 255) begin
                check("t4_data_ff", data, 8'hFF);
                check("t4_cnt_ff", word_cnt, 8'hFF);
            end
            if (i == 256) begin
                check("t4_data_wrap", data, 8'h00);
                check("t4_cnt_wrap", word_cnt, 8'h00);
            end
            if (done) nd++;
            tick();
        end
        check("t4_no_done", nd, 0);
        check("t4_busy", busy, 1);
        en_gen = 0;
        #1;
        check("t4_abort_wr", wrreq, 1);
        tick();
        check("t4_abort_idle", busy, 0);
        check("t4_abort_nodone", done, 0);
        check("t4_cnt", word_cnt, 8'h2D);

        // zero seed falls back to SEED; full stalls
        seed_ld = 1; seed = 7'h00; en_gen = 1; mode = 0; burst_len = 8'd5;
        tick();
        seed_ld = 0;
        #1;
        check("t3_w0", data, 8'h01);
        tick();
        check("t3_w1", data, 8'h03);
        tick();
        full = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_full_wrreq", wrreq, 0);
            check("t3_full_data", data, 8'h07);
            check("t3_full_busy", busy, 1);
            tick();
        end
        full = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_wrreq", wrreq, 1);
            check("t3_data", data, t3[i]);
            tick();
        end
        check("t3_done", done, 1);
        check("t3_cnt", word_cnt, 8'd5);
        en_gen = 0;
        tick();

        // seed_ld in RUN ignored; async reset mid-burst
        seed_ld = 1; seed = 7'h11; en_gen = 1; mode = 0; burst_len = 8'd4;
        tick();
        seed = 7'h55;
        #1;
        check("t5_seed", data, 8'h11);
        tick();
        check("t5_run_seed_ign", data, 8'h23);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_wrreq", wrreq, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_cnt", word_cnt, 0);
        check("t5_rst_data", data, 8'h01);
        rst = 1'b0; seed_ld = 0; en_gen = 0;
        tick();
        tick();
        check("t5_post_done", done, 0);
        check("t5_post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
